// File: rtl/step_ctrl.sv
// Front-panel execution controller: debounces the push button and turns it into
// CPU clock-enable pulses (single step, free run or fixed-length burst).
module step_ctrl #(
  parameter int              DEBOUNCE_CYCLES = 1_000_000,
  parameter int              CNT_W           = 20,
  parameter int              RUN_DIV_LOG2    = 17,
  parameter logic [7:0]      BURST_LEN       = 8'd16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_raw,
  input  logic [1:0]  mode,
  output logic        cpu_ce,
  output logic        btn_level,
  output logic        busy,
  output logic [31:0] step_count
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] M_HALT  = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b01;
  localparam logic [1:0] M_RUN   = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

  logic                    s1, s2;
  logic [CNT_W-1:0]        cnt;
  logic                    btn_level_d;
  logic [RUN_DIV_LOG2-1:0] prescaler;
  logic                    press, tick;

  state_t     state, state_n;
  logic [7:0] remaining, remaining_n;
  logic       ce_n;

  // Two-flop synchroniser feeding a stable-sample counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_level_d <= 1'b0;
      prescaler   <= '0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      btn_level_d <= btn_level;
      prescaler   <= prescaler + RUN_DIV_LOG2'(1);
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        btn_level <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = btn_level & ~btn_level_d;
  assign tick  = &prescaler;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    ce_n        = 1'b0;
    unique case (state)
      IDLE: begin
        if (mode == M_RUN) begin
          state_n = RUN;
        end else if (mode == M_STEP && press) begin
          ce_n = 1'b1;
        end else if (mode == M_BURST && press) begin
          state_n     = BURST;
          remaining_n = BURST_LEN;
        end
      end
      RUN: begin
        if (mode != M_RUN) state_n = IDLE;
        else               ce_n    = tick;
      end
      BURST: begin
        if (mode != M_BURST) begin
          state_n     = IDLE;
          remaining_n = '0;
        end else begin
          ce_n        = 1'b1;
          remaining_n = remaining - 8'd1;
          if (remaining == 8'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      remaining  <= '0;
      cpu_ce     <= 1'b0;
      busy       <= 1'b0;
      step_count <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      cpu_ce    <= ce_n;
      busy      <= (state_n != IDLE);
      if (cpu_ce) step_count <= step_count + 32'd1;
    end
  end

  logic unused_halt;
  assign unused_halt = (M_HALT == 2'b00);

endmodule
